// File: rtl/programmable_blinker.sv
`default_nettype none
// ============================================================================
// Module      : programmable_blinker
// Description : Square-wave blink generator. It holds a saturating speed
//               index that is stepped by one-cycle left (faster) and right
//               (slower) pulses. The half-period is 2^(BASE_EXP+MAX_SPEED-speed)
//               clock cycles. tick pulses high on every blink toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_blinker #(
    parameter int SPEED_W       = 3,
    parameter int BASE_EXP      = 20,
    parameter int DEFAULT_SPEED = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               left,
    input  logic               right,
    output logic               blink,
    output logic [SPEED_W-1:0] speed,
    output logic               tick
);

    localparam int MAX_SPEED = (1 << SPEED_W) - 1;
    localparam int CNT_W     = BASE_EXP + MAX_SPEED;

    localparam logic [SPEED_W-1:0] C_MAX_SPEED     = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] C_DEFAULT_SPEED = SPEED_W'(DEFAULT_SPEED);
    localparam logic [SPEED_W-1:0] C_ZERO_SPEED    = '0;

    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_terminal;
    logic               w_tc;
    logic               w_inc;
    logic               w_dec;
    logic               w_change;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic               w_blink_nxt;
    logic               w_tick_nxt;

    // Terminal count HP-1 is an all-ones mask of width (CNT_W - speed), so a
    // right shift of an all-ones word by speed yields it without a subtractor.
    always_comb begin
        w_terminal = {CNT_W{1'b1}} >> speed;
        w_tc       = (r_count == w_terminal);
    end

    // Speed stepping with saturation; simultaneous pulses cancel.
    always_comb begin
        w_inc       = left  & ~right & (speed != C_MAX_SPEED);
        w_dec       = right & ~left  & (speed != C_ZERO_SPEED);
        w_change    = w_inc | w_dec;
        w_speed_nxt = speed;
        if (w_inc) begin
            w_speed_nxt = speed + 1'b1;
        end else if (w_dec) begin
            w_speed_nxt = speed - 1'b1;
        end
    end

    // Counter wraps on terminal count and restarts on an accepted speed change
    // so the new half-period is timed from a clean zero.
    always_comb begin
        w_count_nxt = r_count + 1'b1;
        w_blink_nxt = blink;
        w_tick_nxt  = 1'b0;
        if (w_tc) begin
            w_blink_nxt = ~blink;
            w_tick_nxt  = 1'b1;
        end
        if (w_tc || w_change) begin
            w_count_nxt = '0;
        end
    end

    // State register: all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            speed   <= C_DEFAULT_SPEED;
            blink   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            speed   <= w_speed_nxt;
            blink   <= w_blink_nxt;
            tick    <= w_tick_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_programmable_blinker.sv
`default_nettype none
// ============================================================================
// Module      : tb_programmable_blinker
// Description : Self-checking bench for programmable_blinker with a small
//               configuration (SPEED_W=2, BASE_EXP=1, DEFAULT_SPEED=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_programmable_blinker;

    localparam int SPEED_W       = 2;
    localparam int BASE_EXP      = 1;
    localparam int DEFAULT_SPEED = 1;
    localparam int MAX_SPEED     = (1 << SPEED_W) - 1;

    logic               clk;
    logic               reset;
    logic               left;
    logic               right;
    logic               blink;
    logic [SPEED_W-1:0] speed;
    logic               tick;

    int checks = 0;
    int errors = 0;

    // Reference state of the behavioural model
    int   m_speed = DEFAULT_SPEED;
    int   m_cnt   = 0;
    logic m_blink = 1'b0;
    logic m_tick  = 1'b0;

    logic [SPEED_W+1:0] sb_q[$];

    programmable_blinker #(
        .SPEED_W       (SPEED_W),
        .BASE_EXP      (BASE_EXP),
        .DEFAULT_SPEED (DEFAULT_SPEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .left  (left),
        .right (right),
        .blink (blink),
        .speed (speed),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: compare each produced output against the queued model result
    always @(posedge clk) begin
        logic [SPEED_W+1:0] exp_v;
        #1;
        if (sb_q.size() != 0) begin
            exp_v = sb_q.pop_front();
            checks++;
            if ({blink, speed, tick} !== exp_v) begin
                errors++;
                $display("FAIL scoreboard t=%0t blink/speed/tick actual=%b_%0d_%b expected=%b_%0d_%b",
                         $time, blink, speed, tick, exp_v[SPEED_W+1], exp_v[SPEED_W:1], exp_v[0]);
            end
        end
    end

    // Drive one cycle of inputs, advance the model, push its expectation
    task automatic step(input logic l, input logic r, input logic rs);
        int   hp;
        logic tc;
        logic chg;
        @(negedge clk);
        left  = l;
        right = r;
        reset = rs;
        if (rs) begin
            m_speed = DEFAULT_SPEED;
            m_cnt   = 0;
            m_blink = 1'b0;
            m_tick  = 1'b0;
        end else begin
            hp  = 1 << (BASE_EXP + MAX_SPEED - m_speed);
            tc  = (m_cnt == hp - 1);
            chg = 1'b0;
            if (l && !r && m_speed < MAX_SPEED) begin
                m_speed = m_speed + 1;
                chg     = 1'b1;
            end else if (r && !l && m_speed > 0) begin
                m_speed = m_speed - 1;
                chg     = 1'b1;
            end
            m_tick = tc;
            if (tc) m_blink = ~m_blink;
            m_cnt = (tc || chg) ? 0 : m_cnt + 1;
        end
        sb_q.push_back({m_blink, SPEED_W'(m_speed), m_tick});
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        int ticks[$];
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (blink !== 1'b0 || speed !== 2'd1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state actual=%b_%0d_%b expected=0_1_0", blink, speed, tick);
        end
        for (int e = 1; e <= 40; e++) begin
            step(1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) ticks.push_back(e);
            if (e == 7 || e == 8 || e == 16 || e == 24) begin
                checks++;
                if (blink !== ((e == 16 || e == 7) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL freerun_blink edge=%0d actual=%b", e, blink);
                end
            end
        end
        checks++;
        if (ticks.size() != 5) begin
            errors++;
            $display("FAIL freerun_tick_count actual=%0d expected=5", ticks.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ticks[i] != 8 * (i + 1)) begin
                    errors++;
                    $display("FAIL freerun_tick_edge idx=%0d actual=%0d expected=%0d", i, ticks[i], 8 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_left_pulses;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);                 // edge 1
        checks++;
        if (speed !== 2'd2) begin
            errors++;
            $display("FAIL left1_speed actual=%0d expected=2", speed);
        end
        for (int e = 2; e <= 10; e++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);                 // edge 11
        checks++;
        if (speed !== 2'd3) begin
            errors++;
            $display("FAIL left2_speed actual=%0d expected=3", speed);
        end
        for (int e = 12; e <= 30; e++) begin
            step((e == 22) ? 1'b1 : 1'b0, 1'b0, 1'b0);   // third pulse saturates
            checks++;
            if (tick !== ((e >= 13 && (e % 2) == 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL fast_tick edge=%0d actual=%b", e, tick);
            end
        end
        checks++;
        if (speed !== 2'd3) begin
            errors++;
            $display("FAIL left_saturate_speed actual=%0d expected=3", speed);
        end
    endtask

    task automatic test_right_saturate;
        step(1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 5; e++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);                 // edge 6, counter was 5
        checks++;
        if (speed !== 2'd0 || blink !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL right_change actual=%b_%0d_%b expected=0_0_0", blink, speed, tick);
        end
        for (int e = 7; e <= 40; e++) begin
            step(1'b0, (e == 30) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (tick !== ((e == 22 || e == 38) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL slow_tick edge=%0d actual=%b", e, tick);
            end
        end
        checks++;
        if (speed !== 2'd0 || blink !== 1'b0) begin
            errors++;
            $display("FAIL right_saturate actual=%b_%0d expected=0_0", blink, speed);
        end
    endtask

    task automatic test_simultaneous;
        step(1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 40; e++) begin
            step((e == 3) ? 1'b1 : 1'b0, (e == 3) ? 1'b1 : 1'b0, 1'b0);
            checks++;
            if (tick !== (((e % 8) == 0) ? 1'b1 : 1'b0) || speed !== 2'd1) begin
                errors++;
                $display("FAIL simultaneous edge=%0d tick=%b speed=%0d", e, tick, speed);
            end
        end
    endtask

    task automatic test_tc_left;
        step(1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 7; e++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);                 // edge 8, terminal count
        checks++;
        if (blink !== 1'b1 || tick !== 1'b1 || speed !== 2'd2) begin
            errors++;
            $display("FAIL tc_left actual=%b_%0d_%b expected=1_2_1", blink, speed, tick);
        end
        for (int e = 9; e <= 14; e++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (tick !== ((e == 12) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL tc_left_next edge=%0d actual=%b", e, tick);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int e = 3; e <= 8; e++) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (blink !== 1'b1 || speed !== 2'd3) begin
            errors++;
            $display("FAIL pre_reset actual=%b_%0d expected=1_3", blink, speed);
        end
        step(1'b1, 1'b0, 1'b1);                 // reset with coincident left
        checks++;
        if (blink !== 1'b0 || speed !== 2'd1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid actual=%b_%0d_%b expected=0_1_0", blink, speed, tick);
        end
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (blink !== ((e == 8) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL reset_mid_rise edge=%0d actual=%b", e, blink);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        left  = 1'b0;
        right = 1'b0;
        test_reset();
        test_left_pulses();
        test_right_saturate();
        test_simultaneous();
        test_tc_left();
        test_reset_mid();
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/programmable_blinker.md
Name: programmable_blinker

Overview:
- Blink generator driven by the master FSM's one-cycle increment/decrement pulses (left = faster, right = slower).
- Holds a saturating speed index; produces a 50%-duty square wave whose half-period is a power of two set by that index.
- Output feeds the display mux as the "blinker" source; one instance per blinker channel.

Parameters:
- SPEED_W, 3, width of speed index. MAX_SPEED = 2^SPEED_W - 1.
- BASE_EXP, 20, log2 of half-period (in clk cycles) at speed = MAX_SPEED.
- DEFAULT_SPEED, 3, speed index loaded on reset. Must be <= MAX_SPEED.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; overrides all other inputs.
- left  input  1  one-cycle pulse: increase speed (halve half-period).
- right  input  1  one-cycle pulse: decrease speed (double half-period).
- blink  output  1  square-wave output.
- speed  output  SPEED_W  current speed index, registered.
- tick  output  1  registered, one-cycle pulse coincident with each blink toggle.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: speed = DEFAULT_SPEED, counter = 0, blink = 0, tick = 0.
- Half-period: HP = 2^(BASE_EXP + MAX_SPEED - speed) cycles.
- Counter width: BASE_EXP + MAX_SPEED bits, unsigned, no overflow possible.
- Counter operation, each edge with reset low:
  - If counter == HP-1: counter <= 0, blink <= ~blink, tick <= 1.
  - Otherwise: counter <= counter + 1, tick <= 0.
- Timing: first blink rise occurs on the HP-th rising edge after reset deasserts. Each level then lasts exactly HP cycles while speed is unchanged.
- Speed state machine: register speed in 0..MAX_SPEED.
  - left=1, right=0, speed < MAX_SPEED: speed <= speed+1 (accepted).
  - right=1, left=0, speed > 0: speed <= speed-1 (accepted).
  - left=1, speed == MAX_SPEED: ignored, saturate.
  - right=1, speed == 0: ignored, saturate.
  - left and right both 1 in the same cycle: ignored, no change.
- Accepted change: the new speed is visible on the port the cycle after the pulse. Counter is cleared to 0 on the same edge, so the new HP timing starts fresh. blink level is held (no glitch) unless the same edge is a terminal count.
- Terminal count coincident with an accepted change: blink still toggles and tick=1; counter is cleared.
- Ignored pulses (saturation or simultaneous) leave counter, blink and speed untouched.
- Input pulses are assumed one cycle wide (single-pulse upstream). A held level is treated as one step per cycle; no internal edge detect.
- Reset mid-count or mid-pulse: all state returns to reset values on that edge; a pulse coincident with reset is discarded.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan (SPEED_W=2, BASE_EXP=1, DEFAULT_SPEED=1 → reset HP=8; speed 3→HP 2, speed 0→HP 16):
- Reset, then free-run 40 cycles -> speed=1. blink=0 for edges 1-7, rises at edge 8, falls at edge 16, rises at edge 24. tick high exactly on edges 8, 16, 24, 32, 40.
- Two left pulses 10 cycles apart -> speed 2 then 3. After the second pulse blink period is 4 cycles (HP=2). Third left pulse -> speed stays 3 and the counter phase is unaffected.
- Right pulse at counter=5 with speed=1 -> next cycle speed=0, counter=0, blink unchanged. Next toggle occurs exactly 16 edges after the pulse edge. Further right -> ignored.
- left and right asserted together at speed=1 -> speed stays 1, toggle times identical to the no-pulse run.
- Left pulse on the terminal-count edge (counter=7) -> blink toggles, tick=1, speed=2, next toggle 4 edges later.
- Reset asserted mid-period with blink=1, speed=3 and a simultaneous left pulse -> next cycle blink=0, speed=1, tick=0. Next rise at 8 edges after reset release.
